alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execution unit that consumes an operand pair and an opcode from the test controller stage and produces a registered result. Supports bitwise NOT and a logical shift-right by a variable amount; the shift runs as an iterative one-bit-per-cycle shifter. Sits directly downstream of the operand/opcode controller and upstream of any result sink. Valid/ready handshakes on both sides.

## Interface
- WIDTH, 7, operand and result width in bits.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; SHR amount, unsigned. Ignored for NOT.
- op  input  1  0 = NOT, 1 = SHR.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- result  output  WIDTH  registered result.
- busy  output  1  high in SHIFT or DONE.
- zero  output  1  result == 0. Present only with ALU_FLAGS_EN.
- cout  output  1  last bit shifted out. Present only with ALU_FLAGS_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at the clock edge. Latch a, op, and cnt = min(b, WIDTH). cnt is $clog2(WIDTH+1) bits wide; compare b against WIDTH at full b width before truncating.
  - op=0: result = ~a, next state DONE.
  - op=1, cnt=0: result = a, next state DONE.
  - op=1, cnt>0: work = a, next state SHIFT.
- SHIFT: on each edge, work = work >> 1 with a zero fill, cnt = cnt-1, and capture the shifted-out bit. When cnt reaches 0, result = shifted value and next state DONE.
- DONE: out_valid=1. result is held stable. On out_ready, next state IDLE and out_valid drops.
- Saturation: b >= WIDTH gives result 0.
- The unit does not accept new input while busy. The upstream stage holds in_valid until in_ready.
- Illegal state encoding recovers to IDLE.

## Timing
- Reset values: state IDLE, out_valid=0, result=0, busy=0, zero=0, cout=0. in_ready is 1 once reset is released.
- in_ready is combinational from state. All other outputs are registered.
- Latency from the accept edge to the first out_valid cycle:
  - NOT: 1 cycle.
  - SHR with cnt=0: 1 cycle.
  - SHR with cnt=n: n cycles, n = 1..WIDTH.
- Out-of-reset throughput: one operation per latency + 1 cycles, assuming out_ready=1. The DONE→IDLE cycle is not overlapped.
- Backpressure: out_valid and result stay stable while out_ready=0, for any number of cycles.
- Reset asserted mid-SHIFT or in DONE: outputs return to their reset values immediately (asynchronous). The operation is discarded, no result is emitted, and the unit is in IDLE after release.
- in_valid while busy is ignored and not queued.

## Configuration
- ALU_FLAGS_EN defined: zero and cout ports exist and are registered alongside result.
  - zero = (result == 0).
  - cout: last bit shifted out, i.e. a[min(b,WIDTH)-1] for SHR with n>0; 0 for NOT and for SHR by 0.
- ALU_FLAGS_EN undefined: zero and cout ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg:
  - OP_NOT = 1'b0, OP_SHR = 1'b1.
  - State enum: IDLE, SHIFT, DONE.
  - Default WIDTH constant, shared with the controller.
- Single module. The iterative shifter is about 20 lines and does not warrant a sub-module. No shift_step sub-module.

## Test plan
- NOT: a=1010101, op=0 → out_valid after 1 cycle, result=0101010. With flags: zero=0, cout=0.
- SHR: a=1100110, b=0000011, op=1 → out_valid after 3 cycles, result=0001100. With flags: cout=1.
- SHR by 0 and saturation:
  - a=1100110, b=0 → result=1100110 after 1 cycle.
  - a=1100110, b=0001001 → result=0000000 after 7 cycles. With flags: zero=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable throughout, in_ready=0, a new in_valid is ignored. Release out_ready → IDLE next cycle.
- Reset mid-operation: assert reset 2 cycles into SHR by 5 → out_valid=0 and result=0 immediately, no output is emitted. After release, a NOT of 0000000 gives 1111111.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and the operand/opcode controller feeding it.
package alu_pkg;

    localparam int ALU_WIDTH = 7;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_SHR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic state_is_busy(input alu_state_e s);
        return (s == SHIFT) || (s == DONE);
    endfunction

endpackage

// File: rtl/alu_exec_unit.sv
// Multi-cycle NOT / logical shift-right unit with valid/ready on both sides.
// Optional zero/cout flag outputs are built only when ALU_FLAGS_EN is defined.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             cout,
`endif
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_B  = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_in_s;
    logic [WIDTH-1:0] shift_s;
    logic             accept_s;
    logic             load_s;

    assign in_ready = (state_q == IDLE);
    assign accept_s = in_valid && in_ready;
    // Saturate on the full-width amount; truncating first would alias large shifts.
    assign cnt_in_s = (b >= WIDTH_B) ? CNT_MAX : b[CNT_W-1:0];
    assign shift_s  = work_q >> 1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the accept edge performs the first shift, so SHR by n is n cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!accept_s) begin
                    state_d = IDLE;
                end else if ((op == OP_NOT) || (cnt_in_s <= CNT_ONE)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        work_d   = work_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (!accept_s) begin
                    load_s = 1'b0;
                end else if (op == OP_NOT) begin
                    load_s   = 1'b1;
                    result_d = ~a;
                end else if (cnt_in_s == CNT_ZERO) begin
                    load_s   = 1'b1;
                    result_d = a;
                end else if (cnt_in_s == CNT_ONE) begin
                    load_s   = 1'b1;
                    result_d = a >> 1;
                end else begin
                    work_d = a >> 1;
                    cnt_d  = cnt_in_s - CNT_ONE;
                end
            end
            SHIFT: begin
                work_d = shift_s;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    load_s   = 1'b1;
                    result_d = shift_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            DONE:    load_s = 1'b0;
            default: load_s = 1'b0;
        endcase
        out_valid_d = (state_d == DONE);
        busy_d      = state_is_busy(state_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q      <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            result_q    <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

`ifdef ALU_FLAGS_EN
    logic last_bit_s;
    logic zero_q;
    logic cout_q;

    // Bit leaving the shifter on the edge that loads the result.
    always_comb begin
        if (state_q == SHIFT) begin
            last_bit_s = work_q[0];
        end else if ((op == OP_SHR) && (cnt_in_s != CNT_ZERO)) begin
            last_bit_s = a[0];
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Flags update only together with the result so they stay consistent with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            cout_q <= 1'b0;
        end else if (load_s) begin
            zero_q <= (result_d == {WIDTH{1'b0}});
            cout_q <= last_bit_s;
        end else begin
            zero_q <= zero_q;
            cout_q <= cout_q;
        end
    end

    assign zero = zero_q;
    assign cout = cout_q;
`else
    logic unused_flag_src_s;
    assign unused_flag_src_s = work_q[0] ^ load_s;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit; checks flags when ALU_FLAGS_EN is defined.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        logic         z;
        logic         c;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;
`ifdef ALU_FLAGS_EN
    logic         zero;
    logic         cout;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ALU_FLAGS_EN
        .zero      (zero),
        .cout      (cout),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic oo);
        exp_t e;
        int   n;
        if (oo == OP_NOT) begin
            e.res = ~aa;
            e.lat = 1;
            e.c   = 1'b0;
        end else begin
            n     = (int'(bb) >= W) ? W : int'(bb);
            e.res = (n >= W) ? '0 : (aa >> n);
            e.lat = (n == 0) ? 1 : n;
            e.c   = (n == 0) ? 1'b0 : aa[n-1];
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".result"}, result, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".in_ready"}, in_ready, 1);
`ifdef ALU_FLAGS_EN
        check({tag, ".zero"}, zero, 0);
        check({tag, ".cout"}, cout, 0);
`endif
    endtask

    // One full transaction; hold > 0 keeps out_ready low for that many cycles in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic oo, input int hold);
        exp_t e;
        int   lat;
        sb_q.push_back(model(aa, bb, oo));
        check({tag, ".in_ready"}, in_ready, 1);
        a = aa; b = bb; op = oo; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~aa; b = ~bb; op = ~oo;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".result"}, result, e.res);
        check({tag, ".latency"}, lat, e.lat);
`ifdef ALU_FLAGS_EN
        check({tag, ".zero"}, zero, e.z);
        check({tag, ".cout"}, cout, e.c);
`endif
        for (int i = 0; i < hold; i++) begin
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_result"}, result, e.res);
            check({tag, ".hold_in_ready"}, in_ready, 0);
            in_valid = (i == 1);
            a = 7'b0000000; op = OP_NOT;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".drop_valid"}, out_valid, 0);
        check({tag, ".back_idle"}, in_ready, 1);
        check({tag, ".not_busy"}, busy, 0);
    endtask

    initial begin
        int seen_valid;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = OP_NOT; out_ready = 1'b1;
        #2;
        check_idle_outputs("reset");
        #10;
        reset = 1'b0;
        #1;
        check("post_reset.in_ready", in_ready, 1);
        @(posedge clk); #1;

        run_op("not",      7'b1010101, 7'b0000000, OP_NOT, 0);
        run_op("shr3",     7'b1100110, 7'b0000011, OP_SHR, 0);
        run_op("shr0",     7'b1100110, 7'b0000000, OP_SHR, 0);
        run_op("shr9",     7'b1100110, 7'b0001001, OP_SHR, 0);
        run_op("shr7",     7'b1000001, 7'b0000111, OP_SHR, 0);
        run_op("shr8",     7'b1111111, 7'b0001000, OP_SHR, 0);
        run_op("shr127",   7'b0110110, 7'b1111111, OP_SHR, 0);
        run_op("shr1",     7'b1100111, 7'b0000001, OP_SHR, 0);
        run_op("shr6",     7'b1000000, 7'b0000110, OP_SHR, 0);
        run_op("not_ones", 7'b1111111, 7'b0000101, OP_NOT, 0);
        for (int k = 0; k < 8; k++) begin
            run_op("rand", 7'($urandom), 7'($urandom_range(0, 9)), 1'($urandom), 0);
        end
        run_op("bp_not", 7'b0011001, 7'b0000000, OP_NOT, 5);
        run_op("bp_shr", 7'b1011011, 7'b0000010, OP_SHR, 3);

        // Abort a SHR by 5 two cycles after acceptance.
        a = 7'b1100110; b = 7'd5; op = OP_SHR; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen_valid++;
        end
        check("abort.no_output", seen_valid, 0);
        run_op("not0", 7'b0000000, 7'b0000000, OP_NOT, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
